aes_spi_slave: RTL and testbench

- SPI slave front-end for the AES core. It sits between the SPI master (over the sclk/cs_n/mosi/miso pins) and the AES core.
- Frame 1 receives a 128-bit key and a 128-bit block, then hands both to the core with a valid/ready handshake.
- It captures the core result. Frame 2 shifts the result back to the master.
- All SPI pins are oversampled in the clk domain. There is no second clock.

---
 rtl/aes_spi_pkg.sv | 18 +
 rtl/aes_spi_slave_if.sv | 20 ++
 rtl/spi_pin_sync.sv | 48 ++++
 rtl/aes_spi_slave.sv | 145 ++++++++++++++
 tb/tb_aes_spi_slave.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES SPI slave front-end.
package aes_spi_pkg;

    typedef enum logic [2:0] {IDLE, RX, REQ, WAIT, TXW, TX} state_t;

    localparam int DEF_DATA_W = 128;

    // An RX frame carries key followed by block.
    function automatic int rx_bits(input int w);
        return 2 * w;
    endfunction

    localparam int RX_BITS = rx_bits(DEF_DATA_W);

    localparam logic [7:0] STATUS_OK  = 8'hA5;
    localparam logic [7:0] STATUS_ERR = 8'h5A;

endpackage

// File: rtl/aes_spi_slave_if.sv
// SPI pins plus AES core request/result handshakes for aes_spi_slave.
interface aes_spi_slave_if #(parameter int DATA_W = 128);

    logic              sclk, cs_n, mosi, miso;
    logic [DATA_W-1:0] core_key, core_din, res_data;
    logic              core_valid, core_ready;
    logic              res_valid, res_ready;
    logic              busy, done, err;

    modport slave (
        input  sclk, cs_n, mosi, core_ready, res_data, res_valid,
        output miso, core_key, core_din, core_valid, res_ready, busy, done, err
    );

    modport master (
        output sclk, cs_n, mosi, core_ready, res_data, res_valid,
        input  miso, core_key, core_din, core_valid, res_ready, busy, done, err
    );

endinterface

// File: rtl/spi_pin_sync.sv
// Oversampling synchroniser for sclk/cs_n/mosi with edge detection.
// sclk edges are suppressed while the synchronised cs_n is high.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic cs_s,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
    logic                   sclk_q, cs_q, sclk_s;

    // Synchroniser chains plus one delayed copy for edge detection.
    // cs_n resets high so leaving reset never looks like a frame start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sr <= '0;
            cs_sr   <= '1;
            mosi_sr <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            sclk_q  <= sclk_sr[SYNC_STAGES-1];
            cs_q    <= cs_sr[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sr[SYNC_STAGES-1];
    assign cs_s      = cs_sr[SYNC_STAGES-1];
    assign mosi_s    = mosi_sr[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_q & ~cs_s;
    assign sclk_fall = ~sclk_s &  sclk_q & ~cs_s;
    assign cs_fall   = ~cs_s &  cs_q;
    assign cs_rise   =  cs_s & ~cs_q;

endmodule

// File: rtl/aes_spi_slave.sv
// SPI slave front-end for the AES core: RX frame (key+block) -> core
// request -> result capture -> TX frame.
// Optional macro AES_SPI_STATUS_EN prefixes the TX frame with a status byte.
module aes_spi_slave
    import aes_spi_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    aes_spi_slave_if.slave bus
);

`ifdef AES_SPI_STATUS_EN
    localparam int TX_BITS = DATA_W + 8;
`else
    localparam int TX_BITS = DATA_W;
`endif
    localparam int            RXB    = rx_bits(DATA_W);
    localparam int            CW     = $clog2(RXB + 2);
    localparam logic [CW-1:0] RX_LEN = CW'(RXB);
    localparam logic [CW-1:0] TX_LEN = CW'(TX_BITS);

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [RXB-1:0]      rx_sr, rx_n;
    logic [TX_BITS-1:0]  tx_sr, tx_n;
    logic [DATA_W-1:0]   key_q, key_n, din_q, din_n;
    logic                err_q, err_n, done_q, done_n;
    logic                sclk_rise, sclk_fall, cs_fall, cs_rise, cs_s, mosi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .sclk      (bus.sclk),
        .cs_n      (bus.cs_n),
        .mosi      (bus.mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .cs_s      (cs_s),
        .mosi_s    (mosi_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            rx_sr  <= '0;
            tx_sr  <= '0;
            key_q  <= '0;
            din_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rx_sr  <= rx_n;
            tx_sr  <= tx_n;
            key_q  <= key_n;
            din_q  <= din_n;
            err_q  <= err_n;
            done_q <= done_n;
        end
    end

    // Next-state and datapath updates; cs_n edges take priority over sclk.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rx_n    = rx_sr;
        tx_n    = tx_sr;
        key_n   = key_q;
        din_n   = din_q;
        err_n   = err_q;
        done_n  = 1'b0;
        case (state)
            IDLE: if (cs_fall) begin
                state_n = RX;
                cnt_n   = '0;
                err_n   = 1'b0;
            end
            RX: begin
                if (cs_rise) begin
                    if (cnt == RX_LEN) begin
                        state_n = REQ;
                        key_n   = rx_sr[RXB-1:DATA_W];
                        din_n   = rx_sr[DATA_W-1:0];
                    end else begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end
                end else if (sclk_rise) begin
                    // An extra bit aborts the frame; the rest of it is ignored in IDLE.
                    if (cnt == RX_LEN) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end else begin
                        rx_n  = {rx_sr[RXB-2:0], mosi_s};
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            REQ: if (bus.core_ready) state_n = WAIT;
            WAIT: if (bus.res_valid) begin
                state_n = TXW;
`ifdef AES_SPI_STATUS_EN
                tx_n = {(err_q ? STATUS_ERR : STATUS_OK), bus.res_data};
`else
                tx_n = bus.res_data;
`endif
            end
            TXW: if (cs_fall) begin
                state_n = TX;
                cnt_n   = '0;
            end
            TX: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    if (cnt == TX_LEN) done_n = 1'b1;
                    else               err_n  = 1'b1;
                end else if (sclk_fall) begin
                    tx_n = {tx_sr[TX_BITS-2:0], 1'b0};
                    if (cnt != '1) cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // MSB goes out in the very cycle the TX frame start is detected.
    assign bus.miso       = ((state == TX && !cs_s) || (state == TXW && cs_fall))
                            ? tx_sr[TX_BITS-1] : 1'b0;
    assign bus.core_valid = (state == REQ);
    assign bus.res_ready  = (state == WAIT);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.core_key   = key_q;
    assign bus.core_din   = din_q;

endmodule

// File: tb/tb_aes_spi_slave.sv
// Directed bench for aes_spi_slave: table of RX frames plus hand-written
// back-pressure, short-TX and mid-TX reset sequences.
module tb_aes_spi_slave;

    localparam int DW   = 128;
    localparam int HALF = 4;
`ifdef AES_SPI_STATUS_EN
    localparam int TXB = DW + 8;
`else
    localparam int TXB = DW;
`endif

    typedef struct {
        int           nbits;
        logic [127:0] key;
        logic [127:0] blk;
        logic [127:0] res;
        bit           ok;
    } vec_t;

    logic clk, reset;
    aes_spi_slave_if #(.DATA_W(DW)) bus ();

    aes_spi_slave #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int done_cnt = 0, req_cnt = 0;
    logic cv_q = 1'b0;
    int ready_dly = 3;
    logic [127:0] model_res = '0;

    // Count done pulses and core requests.
    always @(negedge clk) begin
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.core_valid && !cv_q) req_cnt <= req_cnt + 1;
        cv_q <= bus.core_valid;
    end

    // Core model: ready ready_dly cycles after valid, result 20 cycles later.
    initial begin
        bus.core_ready = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_data   = '0;
        forever begin
            @(negedge clk);
            if (bus.core_valid) begin
                repeat (ready_dly - 1) @(negedge clk);
                bus.core_ready = 1'b1;
                @(negedge clk);
                bus.core_ready = 1'b0;
                repeat (20) @(negedge clk);
                bus.res_data  = model_res;
                bus.res_valid = 1'b1;
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    if (!bus.res_ready) break;
                end
                bus.res_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic rx_frame(input logic [255:0] data, input int nbits);
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = (i < 256) ? data[255 - i] : 1'b0;
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Mode-0 master read: sample miso just before each rising sclk.
    task automatic tx_frame(input int nbits, input bit end_frame, output logic [TXB-1:0] got);
        got = '0;
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            got = {got[TXB-2:0], bus.miso};
            bus.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        if (end_frame) begin
            bus.cs_n = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    function automatic logic [TXB-1:0] exp_tx(input logic [127:0] r);
`ifdef AES_SPI_STATUS_EN
        return {8'hA5, r};
`else
        return r;
`endif
    endfunction

    vec_t vecs[6];
    logic [TXB-1:0] got;
    int d0, r0, hold;
    bit stable;

    initial begin
        vecs[0] = '{256, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1};
        vecs[1] = '{200, 128'h0f0e0d0c0b0a09080706050403020100, 128'hffeeddccbbaa99887766554433221100,
                    128'h0, 1'b0};
        vecs[2] = '{256, 128'hfedcba9876543210f0e1d2c3b4a59687, 128'h8899aabbccddeeff0011223344556677,
                    128'h0123456789abcdeffedcba9876543210, 1'b1};
        vecs[3] = '{257, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h0, 1'b0};
        vecs[4] = '{1,   128'h80000000000000000000000000000000, 128'h0, 128'h0, 1'b0};
        vecs[5] = '{256, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, 1'b1};

        bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_outs", {bus.miso, bus.core_valid, bus.res_ready, bus.busy, bus.done, bus.err}, 6'b0);
        chk("rst_key", bus.core_key, 128'h0);
        chk("rst_din", bus.core_din, 128'h0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            d0 = done_cnt; r0 = req_cnt;
            model_res = vecs[v].res; ready_dly = 3;
            rx_frame({vecs[v].key, vecs[v].blk}, vecs[v].nbits);
            if (vecs[v].ok) begin
                chk($sformatf("v%0d_key", v), bus.core_key, vecs[v].key);
                chk($sformatf("v%0d_din", v), bus.core_din, vecs[v].blk);
                chk($sformatf("v%0d_err_rx", v), bus.err, 1'b0);
                repeat (40) @(negedge clk);
                chk($sformatf("v%0d_txw", v), {bus.busy, bus.res_ready, bus.core_valid, bus.miso}, 4'b1000);
                tx_frame(TXB, 1'b1, got);
                repeat (6) @(negedge clk);
                chk($sformatf("v%0d_tx", v), got, exp_tx(vecs[v].res));
                chk($sformatf("v%0d_done", v), done_cnt - d0, 1);
                chk($sformatf("v%0d_req", v), req_cnt - r0, 1);
                chk($sformatf("v%0d_end", v), {bus.busy, bus.err}, 2'b00);
            end else begin
                repeat (10) @(negedge clk);
                chk($sformatf("v%0d_err", v), {bus.err, bus.busy}, 2'b10);
                chk($sformatf("v%0d_noreq", v), req_cnt - r0, 0);
            end
        end

        // Core back-pressure: ready held low for about 50 cycles.
        ready_dly = 50;
        model_res = 128'hcafef00d_0badc0de_12345678_9abcdef0;
        d0 = done_cnt;
        rx_frame({vecs[0].key, vecs[0].blk}, 256);
        hold = 0; stable = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.core_ready) break;
            if (bus.core_valid !== 1'b1 || bus.core_key !== vecs[0].key || bus.core_din !== vecs[0].blk)
                stable = 1'b0;
            hold++;
        end
        chk("bp_stable", stable, 1'b1);
        chk("bp_hold_ge45", hold >= 45, 1'b1);
        chk("bp_valid_at_ready", {bus.core_ready, bus.core_valid}, 2'b11);
        @(negedge clk);
        chk("bp_handshake", {bus.core_valid, bus.res_ready}, 2'b01);
        repeat (30) @(negedge clk);
        tx_frame(TXB, 1'b1, got);
        repeat (6) @(negedge clk);
        chk("bp_tx", got, exp_tx(model_res));
        chk("bp_done", done_cnt - d0, 1);
        ready_dly = 3;

        // TX frame too short: error, no done.
        model_res = vecs[5].res;
        d0 = done_cnt;
        rx_frame({vecs[5].key, vecs[5].blk}, 256);
        repeat (40) @(negedge clk);
        tx_frame(100, 1'b1, got);
        repeat (6) @(negedge clk);
        chk("short_tx_bits", got[99:0], exp_tx(model_res) >> (TXB - 100));
        chk("short_tx_err", {bus.err, bus.busy}, 2'b10);
        chk("short_tx_nodone", done_cnt - d0, 0);

        // Reset in the middle of a TX frame.
        model_res = vecs[0].res;
        rx_frame({vecs[0].key, vecs[0].blk}, 256);
        repeat (40) @(negedge clk);
        d0 = done_cnt;
        tx_frame(64, 1'b0, got);
        chk("mid_tx_busy", bus.busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_tx_rst", {bus.miso, bus.busy, bus.done, bus.core_valid}, 4'b0);
        bus.cs_n = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_tx_nodone", done_cnt - d0, 0);
        chk("mid_tx_idle", {bus.busy, bus.err, bus.core_key}, 130'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
